// File: rtl/uart_mem_bridge_pkg.sv
// ---------------------------------------------------------------------------
// uart_mem_bridge_pkg
// Shared definitions for the UART-to-memory command bridge: protocol command
// and response bytes, the FSM state type, and small decode helpers.
// ---------------------------------------------------------------------------
package uart_mem_bridge_pkg;

   // Command bytes (first byte of a command)
   localparam logic [7:0] CMD_PING  = 8'h50;   // 'P'
   localparam logic [7:0] CMD_WRITE = 8'h57;   // 'W'
   localparam logic [7:0] CMD_READ  = 8'h52;   // 'R'

   // Response bytes
   localparam logic [7:0] RSP_ACK = 8'h4B;     // 'K'
   localparam logic [7:0] RSP_NAK = 8'h3F;     // '?'
   localparam logic [7:0] RSP_ERR = 8'h21;     // '!'

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_ADDRH = 4'd1,
      S_ADDRL = 4'd2,
      S_LEN   = 4'd3,
      S_WDATA = 4'd4,
      S_WMEM  = 4'd5,
      S_RMEM  = 4'd6,
      S_RCAP  = 4'd7,
      S_RSEND = 4'd8,
      S_REPLY = 4'd9
   } state_e;

   // A length byte of zero encodes a 256-byte transfer.
   function automatic logic [8:0] len_decode(input logic [7:0] n);
      return (n == 8'd0) ? 9'd256 : {1'b0, n};
   endfunction

   // States in which a received byte may be consumed.
   function automatic logic is_accept_state(input state_e s);
      case (s)
         S_IDLE, S_ADDRH, S_ADDRL, S_LEN, S_WDATA: return 1'b1;
         default:                                  return 1'b0;
      endcase
   endfunction

   // States in which the inter-byte timeout is armed (mid-command waits).
   function automatic logic is_timed_state(input state_e s);
      case (s)
         S_ADDRH, S_ADDRL, S_LEN, S_WDATA: return 1'b1;
         default:                          return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_mem_bridge_timer.sv
// ---------------------------------------------------------------------------
// uart_mem_bridge_timer
// Inter-byte idle counter. Counts enabled cycles since the last clear and
// flags expiry once TIMEOUT idle cycles have elapsed. Disabling the timer
// also returns it to zero, so it only ever measures one contiguous wait.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   clear_i     - restart the count (a byte was consumed)
//   enable_i    - count this cycle
//   expired_o   - TIMEOUT idle cycles reached while enabled
// ---------------------------------------------------------------------------
module uart_mem_bridge_timer #(
   parameter logic [23:0] TIMEOUT = 24'd1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int CW = $clog2({8'd0, TIMEOUT} + 32'd1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Next count: saturate at LIMIT so expiry stays asserted until acted upon.
   always_comb begin
      count_d = count_q;
      if (clear_i || !enable_i) begin
         count_d = '0;
      end else if (count_q != LIMIT) begin
         count_d = count_q + CW'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = enable_i && (count_q == LIMIT);

endmodule

// File: rtl/uart_mem_bridge.sv
// ---------------------------------------------------------------------------
// uart_mem_bridge
// Serial loader / debug monitor. Decodes P (ping), W (write) and R (read)
// commands arriving from the UART core, performs byte accesses on the system
// memory bus while holding the CPU off the bus, and returns replies through
// the UART transmitter.
// Ports:
//   clk, reset                     - clock, asynchronous active-high reset
//   uart_q/rxvalid/rxoverr/rxframeer - received byte and its status
//   uart_rd                        - consume received byte (same cycle)
//   uart_d/uart_wr/uart_txrdy      - transmit byte, start strobe, tx idle
//   mem_addr/wdata/we/re/rdata     - memory bus; rdata valid 1 cycle after re
//   cpu_halt                       - bridge owns the bus during W/R commands
// ---------------------------------------------------------------------------
module uart_mem_bridge
   import uart_mem_bridge_pkg::*;
#(
   parameter logic [23:0] TIMEOUT = 24'd1_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  uart_q,
   input  logic        uart_rxvalid,
   input  logic        uart_rxoverr,
   input  logic        uart_rxframeer,
   output logic        uart_rd,
   output logic [7:0]  uart_d,
   output logic        uart_wr,
   input  logic        uart_txrdy,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_we,
   output logic        mem_re,
   input  logic [7:0]  mem_rdata,
   output logic        cpu_halt
);

   state_e      state_q;
   logic        is_read_q;
   logic [8:0]  count_q;
   logic        rd_block_q;
   logic [7:0]  uart_d_q;
   logic [15:0] mem_addr_q;
   logic [7:0]  mem_wdata_q;
   logic        mem_we_q;
   logic        mem_re_q;
   logic        cpu_halt_q;

   logic consume_s;
   logic rx_err_s;
   logic timer_en_s;
   logic expired_s;

   // rd_block_q masks rxvalid for the cycle after a consume, while the core
   // is still clearing it; it resets high so uart_rd is low during reset.
   assign consume_s  = is_accept_state(state_q) && uart_rxvalid && !rd_block_q;
   assign rx_err_s   = uart_rxframeer || uart_rxoverr;
   assign timer_en_s = is_timed_state(state_q);

   // Each transmit state leaves on its strobe, and the core drops txrdy after
   // a strobe, so uart_wr can never be high on two consecutive cycles.
   assign uart_rd   = consume_s;
   assign uart_wr   = ((state_q == S_REPLY) || (state_q == S_RSEND)) && uart_txrdy;
   assign uart_d    = uart_d_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_we    = mem_we_q;
   assign mem_re    = mem_re_q;
   assign cpu_halt  = cpu_halt_q;

   uart_mem_bridge_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (consume_s),
      .enable_i  (timer_en_s),
      .expired_o (expired_s)
   );

   // Command FSM with its registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         is_read_q   <= 1'b0;
         count_q     <= 9'd0;
         rd_block_q  <= 1'b1;
         uart_d_q    <= 8'h00;
         mem_addr_q  <= 16'h0000;
         mem_wdata_q <= 8'h00;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         cpu_halt_q  <= 1'b0;
      end else begin
         rd_block_q <= consume_s;
         mem_we_q   <= 1'b0;
         mem_re_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (consume_s) begin
                  // A bad byte is answered with '!' whatever its value.
                  if (rx_err_s) begin
                     uart_d_q <= RSP_ERR;
                     state_q  <= S_REPLY;
                  end else begin
                     case (uart_q)
                        CMD_PING: begin
                           uart_d_q <= RSP_ACK;
                           state_q  <= S_REPLY;
                        end
                        CMD_WRITE: begin
                           is_read_q  <= 1'b0;
                           cpu_halt_q <= 1'b1;
                           state_q    <= S_ADDRH;
                        end
                        CMD_READ: begin
                           is_read_q  <= 1'b1;
                           cpu_halt_q <= 1'b1;
                           state_q    <= S_ADDRH;
                        end
                        default: begin
                           uart_d_q <= RSP_NAK;
                           state_q  <= S_REPLY;
                        end
                     endcase
                  end
               end
            end
            S_ADDRH, S_ADDRL, S_LEN, S_WDATA: begin
               if (consume_s) begin
                  if (rx_err_s) begin
                     uart_d_q <= RSP_ERR;
                     state_q  <= S_REPLY;
                  end else begin
                     case (state_q)
                        S_ADDRH: begin
                           mem_addr_q[15:8] <= uart_q;
                           state_q          <= S_ADDRL;
                        end
                        S_ADDRL: begin
                           mem_addr_q[7:0] <= uart_q;
                           state_q         <= S_LEN;
                        end
                        S_LEN: begin
                           count_q <= len_decode(uart_q);
                           if (is_read_q) begin
                              mem_re_q <= 1'b1;
                              state_q  <= S_RMEM;
                           end else begin
                              state_q <= S_WDATA;
                           end
                        end
                        S_WDATA: begin
                           mem_wdata_q <= uart_q;
                           mem_we_q    <= 1'b1;
                           state_q     <= S_WMEM;
                        end
                        default: begin
                           cpu_halt_q <= 1'b0;
                           state_q    <= S_IDLE;
                        end
                     endcase
                  end
               end else if (expired_s) begin
                  // Silent abort: host stopped mid-command.
                  cpu_halt_q <= 1'b0;
                  state_q    <= S_IDLE;
               end
            end
            S_WMEM: begin
               // Write strobe is on the bus this cycle; advance past it.
               mem_addr_q <= mem_addr_q + 16'd1;
               count_q    <= count_q - 9'd1;
               if (count_q == 9'd1) begin
                  uart_d_q <= RSP_ACK;
                  state_q  <= S_REPLY;
               end else begin
                  state_q <= S_WDATA;
               end
            end
            S_RMEM: begin
               state_q <= S_RCAP;
            end
            S_RCAP: begin
               uart_d_q <= mem_rdata;
               state_q  <= S_RSEND;
            end
            S_RSEND: begin
               if (uart_wr) begin
                  mem_addr_q <= mem_addr_q + 16'd1;
                  count_q    <= count_q - 9'd1;
                  if (count_q == 9'd1) begin
                     cpu_halt_q <= 1'b0;
                     state_q    <= S_IDLE;
                  end else begin
                     mem_re_q <= 1'b1;
                     state_q  <= S_RMEM;
                  end
               end
            end
            S_REPLY: begin
               if (uart_wr) begin
                  cpu_halt_q <= 1'b0;
                  state_q    <= S_IDLE;
               end
            end
            default: begin
               cpu_halt_q <= 1'b0;
               state_q    <= S_IDLE;
            end
         endcase
      end
   end

endmodule
